priority_resolver_isr: RTL and testbench
========================================

// Module: priority_resolver_isr
// PURPOSE
// - Consumes risedBits (unmasked pending requests) from InterruptRequestRegister; picks the winning IR level.
// - Maintains the In-Service Register (ISR); drives INT; runs the two-pulse INTA sequence.
// - Returns the serviced level to the IRR via resetIRR; places the vector on dataBuffer.
// - Sits between the IRR and the data bus buffer / control logic of the 8259A.
// PARAMETERS
// - NUM_IR       8   number of request levels (fixed at 8; index width 3)
// - LOWEST_RESET 7   lowest-priority level after reset (IR0 highest)
// PORTS
// - clk           in   1  system clock, rising edge
// - reset         in   1  asynchronous, active-high reset
// - risedBits     in   8  pending unmasked requests from IRR
// - readPriority  out  1  request to IRR to present risedBits
// - readPriorityAck in 1  IRR acknowledge; risedBits valid this cycle
// - resetIRR      out  3  level being serviced, to IRR
// - resetIRRValid out  1  one-cycle strobe qualifying resetIRR
// - INT           out  1  interrupt request to CPU
// - inta          in   1  one-cycle strobe per CPU INTA pulse
// - vectorBase    in   5  T7..T3 from ICW2
// - eoiCmd        in   1  one-cycle OCW2 EOI strobe
// - eoiSpecific   in   1  1 = specific EOI (use eoiLevel), 0 = non-specific
// - eoiLevel      in   3  level for specific EOI
// - rotateOnEoi   in   1  1 = cleared level becomes lowest priority
// - isrOut        out  8  current ISR contents (for OCW3 read)
// - dataBuffer    out  8  interrupt vector {vectorBase, level}
// - dataValid     out  1  one-cycle strobe qualifying dataBuffer
// BEHAVIOUR
// - Reset (async): ISR=0, lowest=LOWEST_RESET, state=IDLE; all outputs 0.
// - Priority order: (lowest+1) mod 8 highest, wrapping through lowest. Fully nested: a request
//   wins only if it is strictly higher than the highest set ISR bit.
// - IDLE: risedBits!=0 -> REQ (next cycle readPriority=1).
// - REQ: hold readPriority=1 until readPriorityAck=1; latch risedBits; readPriority=0 next cycle; -> ARB.
// - ARB (1 cycle): winner found -> store level n, INT=1, -> WAIT1; none -> IDLE.
// - WAIT1: on inta: INT=0.
//   - if latched bit n is still set in risedBits: ISR[n]=1, resetIRR=n, resetIRRValid=1 for one cycle.
//   - else spurious: n := 7, ISR unchanged, no resetIRRValid.
//   - -> WAIT2.
// - WAIT2: on inta: dataBuffer={vectorBase,n}, dataValid=1 for one cycle; -> IDLE.
//   dataBuffer holds its value until the next vector.
// - inta in IDLE/REQ/ARB: ignored, no outputs.
// - EOI (any state):
//   - non-specific clears the highest-priority set ISR bit; specific clears ISR[eoiLevel].
//   - cleared bit already 0 -> no change.
//   - rotateOnEoi=1 and a bit was cleared -> lowest := cleared level.
// - Same-cycle EOI and WAIT1 inta: EOI is evaluated on the pre-set ISR; both updates apply.
// - isrOut reflects ISR combinationally from the register (registered value).
// CONFIGURATION
// - AUTO_EOI_EN defined:
//   - second inta in WAIT2 also clears ISR[n]; if rotateOnEoi=1, lowest := n in the same cycle.
//   - spurious n=7 clears nothing.
// - AUTO_EOI_EN undefined: ISR bits clear only via eoiCmd.
// TESTING
// - Reset, risedBits=8'h00 -> all outputs 0, isrOut=0, readPriority never asserts.
// - risedBits=8'b0010_1000, ack, vectorBase=5'h08 -> INT=1.
//   - inta #1: resetIRR=3 strobe, isrOut=8'h08.
//   - inta #2: dataBuffer=8'h43.
// - ISR=8'h08, risedBits=8'h20 -> ARB finds no winner, INT stays 0.
//   - then non-specific EOI -> isrOut=0; request IR5 is served (dataBuffer={base,5}).
// - risedBits drops bit 3 between INT and inta #1 -> no resetIRRValid, ISR unchanged, vector={base,7}.
// - rotateOnEoi=1, specific EOI level 4 with ISR=8'h10 -> ISR=0.
//   - next risedBits=8'h21 selects IR5 over IR0.
// - AUTO_EOI_EN: full cycle on IR2 -> isrOut returns to 0 on the inta #2 cycle.
//   - assert reset mid-WAIT2 -> all outputs 0 immediately.

Source files
------------

// File: rtl/priority_resolver_isr.sv
// priority_resolver_isr: 8259A priority resolver, in-service register and INTA sequencer.
// Optional build macro AUTO_EOI_EN: the second INTA pulse also clears the serviced ISR bit.
module priority_resolver_isr #(
  parameter int NUM_IR = 8,
  parameter logic [2:0] LOWEST_RESET = 3'd7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IR-1:0] risedBits,
  output logic              readPriority,
  input  logic              readPriorityAck,
  output logic [2:0]        resetIRR,
  output logic              resetIRRValid,
  output logic              INT,
  input  logic              inta,
  input  logic [4:0]        vectorBase,
  input  logic              eoiCmd,
  input  logic              eoiSpecific,
  input  logic [2:0]        eoiLevel,
  input  logic              rotateOnEoi,
  output logic [NUM_IR-1:0] isrOut,
  output logic [7:0]        dataBuffer,
  output logic              dataValid
);
  typedef enum logic [2:0] {IDLE, REQ, ARB, WAIT1, WAIT2} stateT;
  stateT state, nextState;
  logic [NUM_IR-1:0] isr, latched, clrMask, setMask;
  logic [2:0] lowest, nextLowest, level, eoiLvl;
  logic [3:0] win, eoiTop;
  logic eoiHit, take, give, genuine;
`ifdef AUTO_EOI_EN
  logic spurious;
`endif
  // Scan from highest priority (low+1) downward; a set blk bit stops the scan,
  // so a request only wins when strictly above every in-service level.
  function automatic logic [3:0] pickTop(input logic [7:0] req, input logic [7:0] blk, input logic [2:0] low);
    logic done;
    logic [2:0] idx;
    logic [3:0] res;
    done = 1'b0;
    res = 4'd0;
    for (int i = 1; i <= 8; i++) begin
      idx = low + 3'(i);
      if (!done && blk[idx]) done = 1'b1;
      else if (!done && req[idx]) begin
        done = 1'b1;
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction
  assign win = pickTop(latched, isr, lowest);
  assign eoiTop = pickTop(isr, 8'h00, lowest);
  assign eoiLvl = eoiSpecific ? eoiLevel : eoiTop[2:0];
  assign eoiHit = eoiCmd && (eoiSpecific ? isr[eoiLevel] : eoiTop[3]);
  assign take = state == WAIT1 && inta;
  assign give = state == WAIT2 && inta;
  assign genuine = risedBits[level];
  assign readPriority = state == REQ;
  assign INT = state == WAIT1;
  assign isrOut = isr;
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    nextState = |risedBits ? REQ : IDLE;
      REQ:     nextState = readPriorityAck ? ARB : REQ;
      ARB:     nextState = win[3] ? WAIT1 : IDLE;
      WAIT1:   nextState = inta ? WAIT2 : WAIT1;
      WAIT2:   nextState = inta ? IDLE : WAIT2;
      default: nextState = IDLE;
    endcase
  end
  // EOI sees the ISR before this cycle's INTA set; both edits land together.
  always_comb begin
    clrMask = eoiHit ? 8'b1 << eoiLvl : 8'h00;
    setMask = take && genuine ? 8'b1 << level : 8'h00;
    nextLowest = eoiHit && rotateOnEoi ? eoiLvl : lowest;
`ifdef AUTO_EOI_EN
    clrMask = give && !spurious ? clrMask | 8'b1 << level : clrMask;
    nextLowest = give && !spurious && rotateOnEoi ? level : nextLowest;
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nextState;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isr <= '0;
      lowest <= LOWEST_RESET;
      latched <= '0;
      level <= 3'd0;
      resetIRR <= 3'd0;
      resetIRRValid <= 1'b0;
      dataBuffer <= 8'h00;
      dataValid <= 1'b0;
`ifdef AUTO_EOI_EN
      spurious <= 1'b0;
`endif
    end else begin
      isr <= (isr & ~clrMask) | setMask;
      lowest <= nextLowest;
      resetIRRValid <= take && genuine;
      dataValid <= give;
      if (state == REQ && readPriorityAck) latched <= risedBits;
      if (state == ARB) level <= win[2:0];
      if (take && genuine) resetIRR <= level;
      if (take && !genuine) level <= 3'd7;
`ifdef AUTO_EOI_EN
      if (take) spurious <= !genuine;
`endif
      if (give) dataBuffer <= {vectorBase, level};
    end
  end
endmodule

// File: tb/tb_priority_resolver_isr.sv
// tb_priority_resolver_isr: directed checks of arbitration, ISR, EOI/rotation and INTA vectors.
module tb_priority_resolver_isr;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] risedBits = 8'h00;
  logic readPriority, readPriorityAck = 1'b0;
  logic [2:0] resetIRR;
  logic resetIRRValid, INT, inta = 1'b0;
  logic [4:0] vectorBase = 5'h08;
  logic eoiCmd = 1'b0, eoiSpecific = 1'b0, rotateOnEoi = 1'b0;
  logic [2:0] eoiLevel = 3'd0;
  logic [7:0] isrOut, dataBuffer;
  logic dataValid;
  int checks = 0, passes = 0;
  always #5 clk = ~clk;
  priority_resolver_isr dut (
    .clk(clk), .reset(reset), .risedBits(risedBits), .readPriority(readPriority),
    .readPriorityAck(readPriorityAck), .resetIRR(resetIRR), .resetIRRValid(resetIRRValid),
    .INT(INT), .inta(inta), .vectorBase(vectorBase), .eoiCmd(eoiCmd), .eoiSpecific(eoiSpecific),
    .eoiLevel(eoiLevel), .rotateOnEoi(rotateOnEoi), .isrOut(isrOut), .dataBuffer(dataBuffer),
    .dataValid(dataValid)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic request(input logic [7:0] r);
    risedBits = r;
    tick;
    check("readPriority", readPriority, 1);
    readPriorityAck = 1'b1;
    tick;
    readPriorityAck = 1'b0;
    check("readPriorityDrop", readPriority, 0);
    tick;
  endtask
  task automatic pulseInta;
    inta = 1'b1;
    tick;
    inta = 1'b0;
  endtask
  task automatic eoi(input logic spec, input logic [2:0] lvl, input logic rot);
    eoiCmd = 1'b1;
    eoiSpecific = spec;
    eoiLevel = lvl;
    rotateOnEoi = rot;
    tick;
    eoiCmd = 1'b0;
    rotateOnEoi = 1'b0;
  endtask
  initial begin
    repeat (3) tick;
    check("rstReadPriority", readPriority, 0);
    check("rstINT", INT, 0);
    check("rstResetIRRValid", resetIRRValid, 0);
    check("rstResetIRR", resetIRR, 0);
    check("rstDataValid", dataValid, 0);
    check("rstDataBuffer", dataBuffer, 0);
    check("rstIsr", isrOut, 0);
    reset = 1'b0;
    repeat (4) tick;
    check("idleNoRead", readPriority, 0);
    pulseInta;
    check("idleIntaNoStrobe", resetIRRValid, 0);
    check("idleIntaNoData", dataValid, 0);
`ifdef AUTO_EOI_EN
    request(8'h04);
    check("autoINT", INT, 1);
    pulseInta;
    check("autoIsrSet", isrOut, 8'h04);
    pulseInta;
    check("autoIsrClr", isrOut, 8'h00);
    check("autoVector", dataBuffer, 8'h42);
`else
    request(8'h28);
    check("ir3INT", INT, 1);
    pulseInta;
    check("ir3INTdrop", INT, 0);
    check("ir3ResetValid", resetIRRValid, 1);
    check("ir3ResetIRR", resetIRR, 3);
    check("ir3Isr", isrOut, 8'h08);
    risedBits = 8'h20;
    tick;
    check("ir3StrobeOne", resetIRRValid, 0);
    pulseInta;
    check("ir3DataValid", dataValid, 1);
    check("ir3Vector", dataBuffer, 8'h43);
    tick;
    check("ir3DataValidDrop", dataValid, 0);
    check("ir3VectorHold", dataBuffer, 8'h43);
    request(8'h20);
    check("nestedBlocked", INT, 0);
    eoi(1'b0, 3'd0, 1'b0);
    check("nsEoiClr", isrOut, 8'h00);
    request(8'h20);
    check("ir5INT", INT, 1);
    pulseInta;
    check("ir5ResetIRR", resetIRR, 5);
    check("ir5Isr", isrOut, 8'h20);
    risedBits = 8'h00;
    pulseInta;
    check("ir5Vector", dataBuffer, 8'h45);
    eoi(1'b0, 3'd0, 1'b0);
    check("ir5EoiClr", isrOut, 8'h00);
    request(8'h08);
    check("spurINT", INT, 1);
    risedBits = 8'h00;
    pulseInta;
    check("spurNoStrobe", resetIRRValid, 0);
    check("spurIsr", isrOut, 8'h00);
    check("spurINTdrop", INT, 0);
    pulseInta;
    check("spurVector", dataBuffer, 8'h47);
    request(8'h10);
    pulseInta;
    check("ir4Isr", isrOut, 8'h10);
    risedBits = 8'h00;
    pulseInta;
    check("ir4Vector", dataBuffer, 8'h44);
    eoi(1'b1, 3'd4, 1'b1);
    check("specEoiClr", isrOut, 8'h00);
    request(8'h21);
    check("rotINT", INT, 1);
    pulseInta;
    check("rotPicksIr5", resetIRR, 5);
    risedBits = 8'h00;
    pulseInta;
    eoi(1'b1, 3'd2, 1'b1);
    check("specEoiNoop", isrOut, 8'h20);
    eoi(1'b0, 3'd0, 1'b0);
    check("nsEoiIr5", isrOut, 8'h00);
    vectorBase = 5'h1F;
    request(8'h09);
    pulseInta;
    check("rotKeptIr0", resetIRR, 0);
    risedBits = 8'h00;
    pulseInta;
    check("ir0Vector", dataBuffer, 8'hF8);
    eoi(1'b0, 3'd0, 1'b0);
    check("ir0EoiClr", isrOut, 8'h00);
`endif
    request(8'h04);
    pulseInta;
    risedBits = 8'h00;
    check("midIsr", isrOut, 8'h04);
    reset = 1'b1;
    #1;
    check("midRstIsr", isrOut, 8'h00);
    check("midRstINT", INT, 0);
    check("midRstRead", readPriority, 0);
    check("midRstData", dataBuffer, 8'h00);
    check("midRstResetIRR", resetIRR, 0);
    reset = 1'b0;
    tick;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
